// File: rtl/jam_pkg.sv
// Shared types and width helpers for the exhaustive job-assignment solver.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COST,
    CMP,
    STEP,
    DONE
  } jam_state_t;

  function automatic int iw_f(input int n);
    return $clog2(n);
  endfunction

  // Sum of N costs never exceeds N*(2^CW-1), so CW+clog2(N) bits always hold it.
  function automatic int sw_f(input int n, input int cw);
    return cw + $clog2(n);
  endfunction

endpackage

// File: rtl/jam_param_if.sv
// Start/result handshake and cost-table lookup bus of the job-assignment solver.
interface jam_param_if
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
);
  localparam int IW = iw_f(N);
  localparam int SW = sw_f(N, CW);

  logic            start;
  logic [IW-1:0]   W;
  logic [IW-1:0]   J;
  logic [CW-1:0]   Cost;
  logic            Busy;
  logic            Valid;
  logic [SW-1:0]   MinCost;
  logic [MCW-1:0]  MatchCount;
  logic [N*IW-1:0] BestJob;

  modport master (
    output start, Cost,
    input  W, J, Busy, Valid, MinCost, MatchCount, BestJob
  );

  modport slave (
    input  start, Cost,
    output W, J, Busy, Valid, MinCost, MatchCount, BestJob
  );
endinterface

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of an N-element permutation.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = iw_f(N)
) (
  input  logic [N-1:0][IW-1:0] perm,
  output logic [N-1:0][IW-1:0] next_perm,
  output logic                 last
);

  logic [N-2:0] asc;

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_asc
      assign asc[gi] = perm[gi] < perm[gi+1];
    end
  endgenerate

  always_comb begin
    int piv;
    int k;
    logic [N-1:0][IW-1:0] swp;
    piv  = 0;
    k    = 0;
    last = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (asc[i]) begin
        piv  = i;
        last = 1'b0;
      end
    end
    for (int j = 1; j < N; j++) begin
      if (j > piv && perm[j] > perm[piv]) k = j;
    end
    swp      = perm;
    swp[piv] = perm[k];
    swp[k]   = perm[piv];
    next_perm = swp;
    // Suffix after the pivot is descending; reversing it gives the smallest tail.
    for (int j = 1; j < N; j++) begin
      if (j > piv) next_perm[j] = swp[N + piv - j];
    end
  end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N x N assignment search: walks all permutations, sums costs, tracks the optimum.
module jam_param
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) (
  input logic       CLK,
  input logic       RST,
  jam_param_if.slave bus
);

  localparam int IW = iw_f(N);
  localparam int SW = sw_f(N, CW);
  localparam logic [IW-1:0] LAST_CNT = IW'(N - 1);

  jam_state_t           state_q, state_d;
  logic [N-1:0][IW-1:0] perm_q, perm_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [SW-1:0]        min_q, min_d;
  logic [MCW-1:0]       match_q, match_d;
  logic [N-1:0][IW-1:0] best_q, best_d;

  logic [N-1:0][IW-1:0] ident;
  logic [N-1:0][IW-1:0] next_perm;
  logic                 last;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ident
      assign ident[gi] = IW'(gi);
    end
  endgenerate

  jam_next_perm #(.N(N), .IW(IW)) u_next (
    .perm      (perm_q),
    .next_perm (next_perm),
    .last      (last)
  );

  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    min_d   = min_q;
    match_d = match_q;
    best_d  = best_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      LOAD: begin
        perm_d  = ident;
        cnt_d   = '0;
        min_d   = '1;
        match_d = '0;
        valid_d = 1'b0;
        state_d = COST;
      end
      COST: begin
        acc_d = (cnt_q == '0) ? SW'(bus.Cost) : acc_q + SW'(bus.Cost);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = CMP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CMP: begin
        if (acc_q < min_q) begin
          min_d   = acc_q;
          match_d = MCW'(1);
          best_d  = perm_q;
        end else if (acc_q == min_q && match_q != {MCW{1'b1}}) begin
          match_d = match_q + 1'b1;
        end
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          state_d = STEP;
        end
      end
      STEP: begin
        perm_d  = next_perm;
        state_d = COST;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      perm_q  <= ident;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '1;
      match_q <= '0;
      best_q  <= ident;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      min_q   <= min_d;
      match_q <= match_d;
      best_q  <= best_d;
    end
  end

  assign bus.W          = cnt_q;
  assign bus.J          = perm_q[cnt_q];
  assign bus.Busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.MinCost    = min_q;
  assign bus.MatchCount = match_q;
  assign bus.BestJob    = best_q;

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised exhaustive job-assignment solver for N workers and N jobs.
- Steps through all N! permutations in lexicographic order. For each permutation it reads N costs from an external cost table over the W/J/Cost bus.
- Reports the minimum total cost, how many permutations achieve it, and the first (lexicographically smallest) optimal assignment.
- Successor to the fixed 8x8 contest solver; adds a start/busy handshake, parametrised N and cost width, and an optimal-assignment output.

Parameters:
N, 8, workers = jobs; legal range 2..8
CW, 7, Cost input width
MCW, 16, MatchCount width
IW (localparam), $clog2(N), worker/job index width
SW (localparam), CW+$clog2(N), sum and MinCost width

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
start  in  1  begin a search; sampled only in IDLE or DONE
W  out  IW  worker index presented to the cost table
J  out  IW  job index presented to the cost table
Cost  in  CW  cost of (W,J); combinational from table, valid in the same cycle
Busy  out  1  high from LOAD until DONE is entered
Valid  out  1  level; high in DONE until the next accepted start or RST
MinCost  out  SW  minimum total cost found
MatchCount  out  MCW  number of permutations whose sum equals MinCost
BestJob  out  N*IW  field w = job assigned to worker w in the first optimal permutation

Behaviour:
- Reset values:
  - State IDLE; perm[i]=i; cnt=0; acc=0.
  - W=0, J=0, Busy=0, Valid=0.
  - MinCost = all ones; MatchCount=0; BestJob = identity.
- Output drive: W=cnt and J=perm[cnt], both from registers. cnt=0 outside COST.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): perm=identity, MinCost=all ones, MatchCount=0, Valid=0 -> COST.
  - COST (N cycles, cnt=0..N-1):
    - Each edge: acc <= (cnt==0) ? Cost : acc+Cost; cnt increments.
    - cnt==N-1 -> CMP; cnt returns to 0.
  - CMP (1 cycle):
    - acc<MinCost: MinCost=acc, MatchCount=1, BestJob=perm.
    - acc==MinCost: MatchCount+1, saturating at 2^MCW-1; BestJob unchanged.
    - Pivot i = largest index with perm[i]<perm[i+1].
    - No pivot (perm descending, last permutation) -> DONE; otherwise -> STEP.
  - STEP (1 cycle): swap perm[i] with perm[k], where k = largest index >i with perm[k]>perm[i]; reverse perm[i+1..N-1]. All combinational, registered at once -> COST.
  - DONE: Valid=1, Busy=0, results held. start=1 -> LOAD.
- Timing: DONE is entered exactly N!*(N+2) edges after the edge that samples start. N=3: 30 edges. N=8: 403200 edges.
- start while Busy: ignored.
- RST mid-search: all state and outputs return to reset values immediately.
- Arithmetic: all unsigned. acc cannot overflow at SW bits. MinCost all ones is an unreachable sentinel, so the first permutation always wins CMP.

Decomposition:
- Package jam_pkg:
  - State enum (IDLE, LOAD, COST, CMP, STEP, DONE).
  - Functions for the IW and SW width derivations.
- Sub-module jam_next_perm: combinational pivot search, swap and suffix reverse over N fields.
  - Inputs: perm.
  - Outputs: next_perm and last flag.
  - Unit-testable on its own.

Test Plan:
- N=3, Cost=W+J -> all 6 sums = 6: MinCost=6, MatchCount=6, BestJob={0,1,2}, Valid rises 30 edges after start.
- N=3, Cost=0 when J==W else 10 -> MinCost=0, MatchCount=1, BestJob=identity.
- N=3, Cost=0 when J==2-W else 5 -> optimum is the last permutation {2,1,0}: MinCost=0, MatchCount=1, checked at the final CMP before DONE.
- N=3, trace W/J over the whole search -> J sequence per permutation follows 012,021,102,120,201,210; each W cycles 0,1,2; Busy high throughout.
- N=8, all Cost=127 -> MinCost=1016, MatchCount=40320, Valid after 403200 edges; start pulses during Busy have no effect.
- N=4: assert RST at cycle 50 -> all outputs at reset values, state IDLE. New start then runs a full search matching a golden model; a back-to-back start from DONE re-runs and clears Valid in LOAD.
